// File: rtl/ct_idu_is_aiq_lch_sel_if.sv
// ct_idu_is_aiq_lch_sel_if: create/ready/launch-control inputs and launch-stage outputs of the AIQ launch selector.
interface ct_idu_is_aiq_lch_sel_if #(
  parameter int ENTRY = 8,
  parameter int IDX_W = 3
);
  logic             create_vld;
  logic [ENTRY-1:0] create_entry;
  logic [ENTRY-1:0] entry_vld;
  logic [ENTRY-1:0] entry_lch_rdy;
  logic             lch_stall;
  logic             lch_cancel;
  logic [ENTRY-1:0] lch_cancel_entry;
  logic             flush;
  logic             lch_vld;
  logic [ENTRY-1:0] lch_entry;
  logic [IDX_W-1:0] lch_idx;
  modport master (
    output create_vld, create_entry, entry_vld, entry_lch_rdy,
           lch_stall, lch_cancel, lch_cancel_entry, flush,
    input  lch_vld, lch_entry, lch_idx
  );
  modport slave (
    input  create_vld, create_entry, entry_vld, entry_lch_rdy,
           lch_stall, lch_cancel, lch_cancel_entry, flush,
    output lch_vld, lch_entry, lch_idx
  );
endinterface

// File: rtl/ct_idu_is_aiq_lch_sel.sv
// ct_idu_is_aiq_lch_sel: age-ordered oldest-ready launch selector with a one-deep launch stage and in-flight mask.
module ct_idu_is_aiq_lch_sel #(
  parameter int ENTRY = 8,
  parameter int IDX_W = 3
) (
  input logic                    forever_cpuclk,
  input logic                    cpurst_b,
  ct_idu_is_aiq_lch_sel_if.slave bus
);
  logic [ENTRY-1:0] age [ENTRY];
  logic [ENTRY-1:0] col [ENTRY];
  logic [ENTRY-1:0] inflight;
  logic [ENTRY-1:0] cand;
  logic [ENTRY-1:0] blk;
  logic [ENTRY-1:0] win;
  logic [ENTRY-1:0] clr;
  logic [ENTRY-1:0] setm;
  logic [IDX_W-1:0] win_idx;
  logic             vld_q;
  logic [ENTRY-1:0] entry_q;
  logic [IDX_W-1:0] idx_q;
  // An entry being created this cycle is never a candidate, even if its valid/ready bits look set.
  assign cand = bus.entry_vld & bus.entry_lch_rdy & ~inflight
              & ~({ENTRY{bus.create_vld}} & bus.create_entry);
  genvar i, j;
  for (i = 0; i < ENTRY; i++) begin : g_col
    for (j = 0; j < ENTRY; j++) begin : g_bit
      assign col[i][j] = age[j][i];
    end
    assign blk[i] = |(cand & col[i]);
  end
  assign win  = cand & ~blk;
  assign clr  = ~bus.entry_vld | ({ENTRY{bus.lch_cancel}} & bus.lch_cancel_entry);
  assign setm = bus.lch_stall ? '0 : win;
  always_comb begin
    win_idx = '0;
    for (int k = 0; k < ENTRY; k++) win_idx = win[k] ? (win_idx | IDX_W'(k)) : win_idx;
  end
  // New entry becomes youngest: its row clears, every currently valid entry becomes older than it.
  always_ff @(posedge forever_cpuclk) begin
    for (int r = 0; r < ENTRY; r++)
      for (int c = 0; c < ENTRY; c++)
        if (!cpurst_b) age[r][c] <= 1'b0;
        else if (bus.create_vld && bus.create_entry[r]) age[r][c] <= 1'b0;
        else if (bus.create_vld && bus.create_entry[c] && r != c) age[r][c] <= bus.entry_vld[r];
  end
  // Set after clear so a relaunch of an entry being cleared keeps it masked.
  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b || bus.flush) begin
      inflight <= '0;
      vld_q    <= 1'b0;
      entry_q  <= '0;
      idx_q    <= '0;
    end else begin
      inflight <= (inflight & ~clr) | setm;
      if (!bus.lch_stall) begin
        vld_q   <= |cand;
        entry_q <= win;
        idx_q   <= win_idx;
      end
    end
  end
  assign bus.lch_vld   = vld_q;
  assign bus.lch_entry = entry_q;
  assign bus.lch_idx   = idx_q;
  a_create_onehot: assert property (@(posedge forever_cpuclk) disable iff (!cpurst_b)
    bus.create_vld |-> $onehot(bus.create_entry));
endmodule
